// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce chain: FSM state encodings,
// legal parameter limits and a small state-decode helper.
package debounce_pkg;

    // Gray-style encoding: bit 1 is the debounced level, and a WAIT state
    // differs from its settled neighbour in one bit.
    localparam logic [1:0] S_LOW       = 2'b00;
    localparam logic [1:0] S_WAIT_HIGH = 2'b01;
    localparam logic [1:0] S_HIGH      = 2'b11;
    localparam logic [1:0] S_WAIT_LOW  = 2'b10;

    localparam int MIN_STABLE_CYCLES = 2;
    localparam int MIN_SYNC_STAGES   = 2;

    // True while a candidate transition is being qualified.
    function automatic logic state_is_busy(input logic [1:0] s);
        return (s == S_WAIT_HIGH) || (s == S_WAIT_LOW);
    endfunction

    // Debounced level presented while sitting in a given state.
    function automatic logic state_level(input logic [1:0] s);
        return (s == S_HIGH) || (s == S_WAIT_LOW);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for bringing an asynchronous input into
// the clk domain. Pure flop chain, reset to 0.
module sync_ff
    import debounce_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least %0d", MIN_SYNC_STAGES);
    end

    // Shift the raw input through the chain; nothing sits between stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Upstream debounce stage: synchronises a bouncing button input and only
// moves the registered level after the new value has been seen for
// STABLE_CYCLES consecutive synchronised samples. Aborted qualifications
// are tallied in a saturating glitch counter for status/debug.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                noisy_in,
    input  logic                glitch_clr,
    output logic                level,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be at least %0d", MIN_STABLE_CYCLES);
    end

    logic             sync;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             abort;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (noisy_in),
        .q       (sync)
    );

    // Next-state and qualification-count logic; the first differing sample
    // is counted as 1, so qualification completes when the count has
    // reached STABLE_CYCLES-1 and one more matching sample arrives.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        case (state)
            S_LOW: begin
                if (sync) begin
                    state_nxt = S_WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                    abort     = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync) begin
                    state_nxt = S_WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_WAIT_LOW: begin
                if (sync) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    abort     = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and the Moore outputs, which are registered decodes of
    // the next state so level and busy come straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= state_level(state_nxt);
            busy  <= state_is_busy(state_nxt);
        end
    end

    // Saturating glitch counter; a clear beats a coincident abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != GLITCH_MAX)) begin
            glitch_cnt <= glitch_cnt + GLITCH_ONE;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with STABLE_CYCLES=4,
// SYNC_STAGES=2, GLITCH_W=3. Each scenario queues its per-edge stimulus
// and expected {level, busy, glitch_cnt}, then steps the clock and
// compares every edge against the popped expectation.
module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    localparam int GW     = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          noisy_in;
    logic          glitch_clr;
    logic          level;
    logic          busy;
    logic [GW-1:0] glitch_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        int         edge_no;
        logic [4:0] vec;
    } exp_t;

    exp_t sb[$];
    bit   din_q[$];
    bit   clr_q[$];

    button_debouncer #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC),
        .GLITCH_W      (GW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .noisy_in   (noisy_in),
        .glitch_clr (glitch_clr),
        .level      (level),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic applyStimulus(input bit d, input bit c);
        noisy_in   = d;
        glitch_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Queue one edge worth of stimulus and its expected outputs.
    task automatic enqueue(input string tag, input int e, input bit d, input bit c,
                           input bit l, input bit b, input int g);
        exp_t x;
        x.tag     = tag;
        x.edge_no = e;
        x.vec     = {l, b, 3'(g)};
        sb.push_back(x);
        din_q.push_back(d);
        clr_q.push_back(c);
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        reset_n    = 1'b0;
        noisy_in   = 1'b0;
        glitch_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {level, busy, glitch_cnt};
        vectors++;
        if (obs !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: {level,busy,glitch_cnt} got %b, want %b", obs, 5'b0);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_press();
        exp_t       x;
        logic [4:0] obs;
        for (int e = 1; e <= 20; e++)
            enqueue("clean_press", e, 1'b1, 1'b0, e >= 6, (e >= 3) && (e <= 5), 0);
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
    endtask

    task automatic test_release();
        exp_t       x;
        logic [4:0] obs;
        for (int e = 1; e <= 12; e++)
            enqueue("release", e, 1'b0, 1'b0, e < 6, (e >= 3) && (e <= 5), 0);
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t       x;
        logic [4:0] obs;
        bit         d;
        bit         b;
        int         g;
        // Input 1,0,1,1,0 then stable 1; level must rise on edge 11 only.
        for (int e = 1; e <= 16; e++) begin
            d = !((e == 2) || (e == 5));
            b = (e == 3) || (e == 5) || (e == 6) || ((e >= 8) && (e <= 10));
            g = (e < 4) ? 0 : (e < 7) ? 1 : 2;
            enqueue("bounce", e, d, 1'b0, e >= 11, b, g);
        end
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
        repeat (10) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        exp_t       x;
        logic [4:0] obs;
        // Three high samples: rejected on the reverting sample.
        for (int e = 1; e <= 10; e++)
            enqueue("boundary_short", e, e <= 3, 1'b0, 1'b0, (e >= 3) && (e <= 5), (e >= 6) ? 3 : 2);
        // Four high samples: accepted, then the fall qualifies back to low.
        for (int e = 1; e <= 12; e++)
            enqueue("boundary_exact", e, e <= 4, 1'b0, (e >= 6) && (e <= 9),
                    ((e >= 3) && (e <= 5)) || ((e >= 7) && (e <= 9)), 3);
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t       x;
        logic [4:0] obs;
        int         gp;
        int         g;
        enqueue("glitch_clear", 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Ten 2-sample pulses; the tenth abort coincides with glitch_clr.
        for (int p = 1; p <= 10; p++) begin
            gp = (p - 1 > 7) ? 7 : p - 1;
            for (int k = 1; k <= 5; k++) begin
                if (k < 5)
                    g = gp;
                else if (p == 10)
                    g = 0;
                else
                    g = (p > 7) ? 7 : p;
                enqueue($sformatf("saturate_p%0d", p), k, k <= 2, (p == 10) && (k == 5),
                        1'b0, (k == 3) || (k == 4), g);
            end
        end
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t       x;
        logic [4:0] obs;
        // Leave one glitch counted, then settle high.
        repeat (2) applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 4; e++)
            enqueue("enter_wait_low", e, 1'b0, 1'b0, 1'b1, e >= 3, 1);
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
        noisy_in = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        obs = {level, busy, glitch_cnt};
        vectors++;
        if (obs !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_mid_wait: {level,busy,glitch_cnt} got %b, want %b", obs, 5'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++)
            enqueue("post_reset_press", e, 1'b1, 1'b0, e >= 6, (e >= 3) && (e <= 5), 0);
        while (sb.size() > 0) begin
            applyStimulus(din_q.pop_front(), clr_q.pop_front());
            x   = sb.pop_front();
            obs = {level, busy, glitch_cnt};
            vectors++;
            if (obs !== x.vec) begin
                miscompares++;
                $display("[TB] FAIL %s edge %0d: {level,busy,glitch_cnt} got %b, want %b",
                         x.tag, x.edge_no, obs, x.vec);
            end
        end
    endtask

    // Scenario sequence; each one starts from the state the previous left.
    initial begin
        $display("[TB] starting button_debouncer bench");
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_boundary();
        test_saturation();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream stage of the debounce chain.
- Takes a raw, asynchronous, bouncing button/switch input and synchronises it into clk.
- Outputs a clean registered `level` only after the input has held a new value for STABLE_CYCLES consecutive cycles.
- `level` feeds the edge-detection stage directly; `busy` and a saturating glitch counter support status/debug.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronised samples of the new value required before `level` changes; legal range >= 2.
- SYNC_STAGES, 2: synchronizer flop count; legal range >= 2.
- GLITCH_W, 8: width of the glitch counter.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset; asynchronous, active-low
- noisy_in  input  1  raw asynchronous button input
- glitch_clr  input  1  synchronous clear of glitch_cnt
- level  output  1  debounced, registered level (to edge detection)
- busy  output  1  high while a candidate transition is being qualified
- glitch_cnt  output  GLITCH_W  saturating count of aborted transitions

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0:
  - all synchronizer flops = 0
  - state = S_LOW, qualification counter = 0
  - level = 0, busy = 0, glitch_cnt = 0
- Synchronizer: SYNC_STAGES-deep flop chain; `sync` = last stage. No logic between stages.
- Qualification counter: width $clog2(STABLE_CYCLES+1).
- FSM is Moore; level and busy are registered state decodes:
  - S_LOW: level=0, busy=0.
  - S_WAIT_HIGH: level=0, busy=1.
  - S_HIGH: level=1, busy=0.
  - S_WAIT_LOW: level=1, busy=1.
- Transitions:
  - S_LOW: sync=1 -> S_WAIT_HIGH, cnt<=1. Otherwise hold.
  - S_WAIT_HIGH:
    - sync=0 -> S_LOW, cnt<=0, glitch increment.
    - sync=1 and cnt==STABLE_CYCLES-1 -> S_HIGH, cnt<=0.
    - otherwise cnt<=cnt+1.
  - S_HIGH: sync=0 -> S_WAIT_LOW, cnt<=1. Otherwise hold.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH with sync polarity inverted; qualifies to S_HIGH->S_LOW path (abort -> S_HIGH, complete -> S_LOW).
  - Unreachable encodings -> S_LOW, cnt<=0.
- Latency:
  - noisy_in changes and then holds stable.
  - Count the first clk edge that captures it as edge 1.
  - `level` changes on edge SYNC_STAGES+STABLE_CYCLES (defaults: edge 18).
- Boundary timing: an input that holds exactly STABLE_CYCLES-1 synchronised samples and then reverts is rejected.
  - `level` is unchanged.
  - glitch_cnt +1 on the reverting sample.
- Glitch counter:
  - Increments by 1 on each abort from either WAIT state.
  - Saturates at 2^GLITCH_W-1; never wraps.
  - glitch_clr=1 forces 0 on the next edge and wins over a same-cycle increment (that increment is lost).
- Reset mid-qualification: abort immediately to the reset state. No glitch is counted, and there is no fast path on release.
  - If noisy_in is held high across reset release, `level` rises after the full latency above, counted from the first post-reset edge.
- `level` is a flop output and never glitches, so the downstream edge detector sees at most one transition per qualified change.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding localparams: S_LOW=2'b00, S_WAIT_HIGH=2'b01, S_HIGH=2'b11, S_WAIT_LOW=2'b10
  - legal-range limits for STABLE_CYCLES and SYNC_STAGES
- Natural sub-module: sync_ff, a parameterised N-stage single-bit synchronizer with async active-low reset to 0.
- FSM, counter and glitch counter stay in button_debouncer.

Test Plan:
All scenarios use STABLE_CYCLES=4, SYNC_STAGES=2, GLITCH_W=3.
- Clean press: noisy_in 0->1 held 20 cycles -> level=1 from edge 6; busy=1 on edges 3..5; glitch_cnt=0.
- Bounce on press: noisy_in pulses 1,0,1,1,0 then stable 1 -> level rises exactly once, 6 edges after the final stable 1; glitch_cnt=2.
- Boundary: noisy_in high for exactly 3 cycles then low -> level stays 0, glitch_cnt=1. Repeat with 4 cycles -> level=1.
- Saturation/clear: 9 rejected 2-cycle pulses -> glitch_cnt=7, held at 7. glitch_clr coincident with a 10th abort -> glitch_cnt=0.
- Reset mid-wait: assert reset_n=0 while busy=1 in S_WAIT_LOW -> level=0, busy=0, glitch_cnt=0 asynchronously. Release with noisy_in=1 -> level=1 on post-reset edge 6.
- Release: from level=1, noisy_in 1->0 held -> level=0 on edge 6; no extra transitions on level.
